// File: rtl/aesl_monitor_pkg.sv
// Shared types for the cosim deadlock-monitor feeders: channel FSM states
// and the width of the block event counter.
package aesl_monitor_pkg;

  localparam int EVT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } chan_state_e;

endpackage

// File: rtl/aesl_axis_stall_chan.sv
// One AXI-Stream channel's stall detector: counts consecutive one-sided
// handshake cycles and latches BLOCKED until a real transfer happens.
module aesl_axis_stall_chan
  import aesl_monitor_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic monitor_en,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic enter_blocked
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(STALL_THRESH - 1);

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_xfer, is_wait;

  assign is_xfer = tvalid & tready;
  assign is_wait = tvalid ^ tready;

  // NOTE: every output of this block is assigned a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!monitor_en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (is_wait) begin
            if (STALL_THRESH == 1) begin
              state_nxt = ST_BLOCKED;
              cnt_nxt   = THRESH_C;
            end else begin
              state_nxt = ST_COUNT;
              cnt_nxt   = CNT_W'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        ST_COUNT: begin
          if (!is_wait) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == LAST_C) begin
            state_nxt = ST_BLOCKED;
            cnt_nxt   = THRESH_C;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_BLOCKED: begin
          // A side withdrawing its request is not evidence the stall resolved.
          if (is_xfer) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign blocked       = (state == ST_BLOCKED);
  assign enter_blocked = (state_nxt == ST_BLOCKED) && (state != ST_BLOCKED);

endmodule

// File: rtl/aesl_axis_stall_detector.sv
// Per-channel AXIS stall flags for the cosim deadlock monitor, plus a
// saturating count of cycles in which any channel newly became blocked.
module aesl_axis_stall_detector
  import aesl_monitor_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              monitor_en,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [EVT_W-1:0]  block_events
);

  logic [NUM_CH-1:0] enter_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    aesl_axis_stall_chan #(
      .CNT_W        (CNT_W),
      .STALL_THRESH (STALL_THRESH)
    ) u_chan (
      .clock         (clock),
      .reset_n       (reset_n),
      .monitor_en    (monitor_en),
      .tvalid        (ch_tvalid[i]),
      .tready        (ch_tready[i]),
      .blocked       (axis_block_sigs[i]),
      .enter_blocked (enter_vec[i])
    );
  end

  assign any_block = |axis_block_sigs;

  // Simultaneous entries count as one event; the count sticks at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      block_events <= '0;
    end else if ((|enter_vec) && (block_events != {EVT_W{1'b1}})) begin
      block_events <= block_events + EVT_W'(1);
    end
  end

endmodule
